// File: rtl/fp16_fma_arbiter.sv
// fp16_fma_arbiter: round-robin sharing of one fixed-latency fp16 FMA among N requesters.
// Each issued beat carries its requester ID down a shadow pipeline so that the FMA result
// can be flagged back to the requester that issued it.
// Optional feature: define FMA_ARB_LOCK_EN to add req_lock[N-1:0], which lets one requester
// hold the arbiter for a multi-beat locked sequence.
module fp16_fma_arbiter #(
   parameter int unsigned N       = 4,
   parameter int unsigned FMA_LAT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N-1:0]      req_valid,
   output logic [N-1:0]      req_ready,
   input  logic [N*16-1:0]   req_a,
   input  logic [N*16-1:0]   req_b,
   input  logic [N*16-1:0]   req_c,
`ifdef FMA_ARB_LOCK_EN
   input  logic [N-1:0]      req_lock,
`endif
   output logic [15:0]       fma_a,
   output logic [15:0]       fma_b,
   output logic [15:0]       fma_c,
   input  logic [15:0]       fma_result,
   output logic [N-1:0]      rsp_valid,
   output logic [15:0]       rsp_data,
   output logic              busy
);

   localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned DW   = 16;

   localparam logic [0:0] ST_OPEN   = 1'b0;
   localparam logic [0:0] ST_LOCKED = 1'b1;

   logic [0:0]      lock_state, lock_state_nxt;
   logic [ID_W-1:0] lock_owner, lock_owner_nxt;
   logic [ID_W-1:0] rr_ptr, rr_ptr_nxt;
   logic            gnt_found;
   logic [ID_W-1:0] gnt_id;
   logic [ID_W-1:0] cand;
   logic            accept;

   logic [FMA_LAT:0] tag_v;
   logic [ID_W-1:0]  tag_id [0:FMA_LAT];

   // Wrap-around successor of a requester index.
   function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
      return ID_W'((32'(id) + 32'd1) % N);
   endfunction

   // Winner selection: lock owner only while locked, otherwise first valid from rr_ptr upward.
   always_comb begin
      gnt_found = 1'b0;
      gnt_id    = '0;
      cand      = '0;
      if (lock_state == ST_LOCKED) begin
         gnt_found = req_valid[lock_owner];
         gnt_id    = lock_owner;
      end else begin
         for (int k = 0; k < int'(N); k++) begin
            cand = ID_W'((32'(rr_ptr) + unsigned'(k)) % N);
            if (!gnt_found && req_valid[cand]) begin
               gnt_found = 1'b1;
               gnt_id    = cand;
            end
         end
      end
   end

   // One-hot grant, suppressed while reset is asserted.
   always_comb begin
      req_ready = '0;
      accept    = gnt_found & ~rst;
      if (accept) req_ready[gnt_id] = 1'b1;
   end

   // Next pointer and lock state; pointer only moves on an accept outside a lock.
   always_comb begin
      lock_state_nxt = lock_state;
      lock_owner_nxt = lock_owner;
      rr_ptr_nxt     = rr_ptr;
      if (accept) begin
`ifdef FMA_ARB_LOCK_EN
         if (req_lock[gnt_id]) begin
            lock_state_nxt = ST_LOCKED;
            lock_owner_nxt = gnt_id;
         end else begin
            lock_state_nxt = ST_OPEN;
            rr_ptr_nxt     = next_id(gnt_id);
         end
`else
         rr_ptr_nxt = next_id(gnt_id);
`endif
      end
   end

   // Arbitration state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         lock_state <= ST_OPEN;
         lock_owner <= '0;
         rr_ptr     <= '0;
      end else begin
         lock_state <= lock_state_nxt;
         lock_owner <= lock_owner_nxt;
         rr_ptr     <= rr_ptr_nxt;
      end
   end

   // Operand stage: winner's triple, or zeros when idle to keep the FMA inputs quiet.
   always_ff @(posedge clk) begin
      if (rst) begin
         fma_a <= '0;
         fma_b <= '0;
         fma_c <= '0;
      end else if (accept) begin
         fma_a <= req_a[32'(gnt_id) * DW +: DW];
         fma_b <= req_b[32'(gnt_id) * DW +: DW];
         fma_c <= req_c[32'(gnt_id) * DW +: DW];
      end else begin
         fma_a <= '0;
         fma_b <= '0;
         fma_c <= '0;
      end
   end

   // Shadow tag pipeline: operand stage plus FMA_LAT stages, never stalls.
   always_ff @(posedge clk) begin
      if (rst) begin
         tag_v <= '0;
         for (int s = 0; s <= int'(FMA_LAT); s++) tag_id[s] <= '0;
      end else begin
         tag_v     <= {tag_v[FMA_LAT-1:0], accept};
         tag_id[0] <= gnt_id;
         for (int s = 1; s <= int'(FMA_LAT); s++) tag_id[s] <= tag_id[s-1];
      end
   end

   // Response routing from the last tag stage; nothing is flagged while in reset.
   always_comb begin
      rsp_valid = '0;
      if (tag_v[FMA_LAT] && !rst) rsp_valid[tag_id[FMA_LAT]] = 1'b1;
   end

   assign rsp_data = fma_result;
   assign busy     = (|tag_v) & ~rst;

endmodule

// File: tb/tb_fp16_fma_arbiter.sv
// Testbench for fp16_fma_arbiter: directed steps plus randomized traffic, checked against a
// queue-based reference of grants and responses. An FMA stand-in with the same latency
// produces deterministic results. Build with FMA_ARB_LOCK_EN defined to exercise locking.
module tb_fp16_fma_arbiter;
   localparam int N   = 4;
   localparam int LAT = 4;

   logic            clk;
   logic            rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_ready;
   logic [N*16-1:0] req_a, req_b, req_c;
`ifdef FMA_ARB_LOCK_EN
   logic [N-1:0]    req_lock;
`endif
   logic [15:0]     fma_a, fma_b, fma_c, fma_result;
   logic [N-1:0]    rsp_valid;
   logic [15:0]     rsp_data;
   logic            busy;

   fp16_fma_arbiter #(.N(N), .FMA_LAT(LAT)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c),
`ifdef FMA_ARB_LOCK_EN
      .req_lock(req_lock),
`endif
      .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_result(fma_result),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in FMA: known values for the directed cases, a scrambling function otherwise.
   function automatic logic [15:0] fstub(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      if (a == 16'h3C00 && b == 16'h4000 && c == 16'h3C00) return 16'h4200;
      if (a == 16'h7C00 && b == 16'h0000 && c == 16'h0000) return 16'h7C01;
      return a ^ {b[7:0], b[15:8]} ^ (c + 16'h1234);
   endfunction

   logic [15:0] fpipe [0:LAT-1];
   always @(posedge clk) begin
      fpipe[0] <= fstub(fma_a, fma_b, fma_c);
      for (int s = 1; s < LAT; s++) fpipe[s] <= fpipe[s-1];
   end
   assign fma_result = fpipe[LAT-1];

   typedef struct {
      int          id;
      logic [15:0] data;
      int          due;
   } rsp_t;

   rsp_t         exp_q[$];
   int           vectors = 0;
   int           miscompares = 0;
   int           cyc = 0;
   int           p_m = 0;
   int           own_m = 0;
   bit           lk_m = 1'b0;
   logic [N-1:0] last_grant;
   logic [N-1:0] pend;
   int           waitc [N];
   int           max_wait;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference arbiter: owner only when locked, else nearest valid requester at or after p.
   function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
      logic [N-1:0] r;
      r = '0;
      if (lk_m) begin
         if (v[own_m]) r[own_m] = 1'b1;
         return r;
      end
      for (int k = N - 1; k >= 0; k--) begin
         if (v[(p_m + k) % N]) begin
            r = '0;
            r[(p_m + k) % N] = 1'b1;
         end
      end
      return r;
   endfunction

   task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
      req_a[16*i +: 16] = a;
      req_b[16*i +: 16] = b;
      req_c[16*i +: 16] = c;
   endtask

   task automatic rand_ops(input int i);
      set_ops(i, 16'($urandom), 16'($urandom), 16'($urandom));
   endtask

   // One clock cycle: check grant/busy/response against the reference, then update it.
   task automatic tick();
      logic [N-1:0] g;
      int id;
      #1;
      g = rst ? '0 : model_grant(req_valid);
      chk("req_ready", 32'(req_ready), 32'(g));
      chk("busy", 32'(busy), (!rst && exp_q.size() > 0) ? 32'd1 : 32'd0);
      if (!rst && exp_q.size() > 0 && exp_q[0].due == cyc) begin
         chk("rsp_valid", 32'(rsp_valid), 32'd1 << exp_q[0].id);
         chk("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
         void'(exp_q.pop_front());
      end else begin
         chk("rsp_valid_idle", 32'(rsp_valid), 32'd0);
      end
      if (rst) begin
         exp_q.delete();
         p_m   = 0;
         lk_m  = 1'b0;
         own_m = 0;
      end else if (g != '0) begin
         id = 0;
         for (int i = 0; i < N; i++) if (g[i]) id = i;
         exp_q.push_back('{id, fstub(req_a[16*id +: 16], req_b[16*id +: 16], req_c[16*id +: 16]),
                           cyc + 1 + LAT});
`ifdef FMA_ARB_LOCK_EN
         if (req_lock[id]) begin
            lk_m  = 1'b1;
            own_m = id;
         end else begin
            lk_m = 1'b0;
            p_m  = (id + 1) % N;
         end
`else
         p_m = (id + 1) % N;
`endif
      end
      last_grant = g;
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req_valid = '0;
      tick();
      rst = 1'b0;
   endtask

   task automatic drain();
      req_valid = '0;
      repeat (LAT + 2) tick();
   endtask

   // Random traffic: requesters hold each beat until granted; track the longest wait.
   task automatic rand_cycles(input int n, input int pct);
      for (int t = 0; t < n; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && int'($urandom_range(99)) < pct) begin
               pend[i] = 1'b1;
               rand_ops(i);
            end
         end
         req_valid = pend;
         tick();
         for (int i = 0; i < N; i++) begin
            if (pend[i] && !last_grant[i]) waitc[i]++;
            else waitc[i] = 0;
            if (waitc[i] > max_wait) max_wait = waitc[i];
         end
         pend = pend & ~last_grant;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_a = '0; req_b = '0; req_c = '0;
`ifdef FMA_ARB_LOCK_EN
      req_lock = '0;
`endif
      pend = '0;
      max_wait = 0;
      for (int i = 0; i < N; i++) waitc[i] = 0;

      // Reset state
      tick();
      tick();
      chk("rst_fma_a", 32'(fma_a), 32'd0);
      chk("rst_fma_c", 32'(fma_c), 32'd0);
      rst = 1'b0;

      // Lone req1: 1.0*2.0+1.0 returns to requester 1 five cycles after accept
      set_ops(1, 16'h3C00, 16'h4000, 16'h3C00);
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      for (int k = 1; k <= 5; k++) begin
         chk("t1_busy", 32'(busy), 32'd1);
         if (k == 5) begin
            chk("t1_rsp_valid", 32'(rsp_valid), 32'h2);
            chk("t1_rsp_data", 32'(rsp_data), 32'h4200);
         end
         tick();
      end
      chk("t1_busy_after", 32'(busy), 32'd0);

      // Lone req3: Inf*0+0 result passed through untouched
      set_ops(3, 16'h7C00, 16'h0000, 16'h0000);
      req_valid = 4'b1000;
      tick();
      req_valid = '0;
      repeat (4) tick();
      chk("t5_rsp_valid", 32'(rsp_valid), 32'h8);
      chk("t5_rsp_data", 32'(rsp_data), 32'h7C01);
      drain();

      // All four valid continuously from reset: strict rotation 0,1,2,3,...
      do_reset();
      for (int i = 0; i < N; i++) rand_ops(i);
      req_valid = '1;
      for (int k = 0; k < 12; k++) begin
         #1;
         chk("t2_grant", 32'(req_ready), 32'd1 << (k % N));
         tick();
         rand_ops(k % N);
      end
      drain();

      // Pointer lands on 2 after granting 1: req3 beats req0, then req0
      do_reset();
      rand_ops(1);
      req_valid = 4'b0010;
      tick();
      rand_ops(0);
      rand_ops(3);
      req_valid = 4'b1001;
      #1;
      chk("t3_grant3", 32'(req_ready), 32'h8);
      tick();
      rand_ops(3);
      #1;
      chk("t3_grant0", 32'(req_ready), 32'h1);
      tick();
      drain();

      // Random valids: every requester served within N-1 waiting cycles
      pend = '0;
      rand_cycles(100, 60);
      for (int t = 0; t < 20 && pend != '0; t++) rand_cycles(1, 0);
      chk("t3_starve", (max_wait <= N - 1) ? 32'd1 : 32'd0, 32'd1);
      drain();

      // Reset with three beats in flight: nothing flagged afterwards, pointer back at 0
      for (int i = 0; i < 3; i++) rand_ops(i);
      req_valid = 4'b0111;
      repeat (3) tick();
      rst = 1'b1;
      req_valid = '0;
      tick();
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         chk("t4_quiet", 32'(rsp_valid), 32'd0);
         tick();
      end
      rand_ops(2);
      rand_ops(3);
      req_valid = 4'b1100;
      #1;
      chk("t4_grant2", 32'(req_ready), 32'h4);
      tick();
      drain();

`ifdef FMA_ARB_LOCK_EN
      // Locked burst from req1 with a gap; req0 waits until the unlocked 4th beat
      do_reset();
      rand_ops(0);
      req_valid = 4'b0001;
      tick();
      rand_ops(0);
      rand_ops(1);
      req_lock = 4'b0010;
      req_valid = 4'b0011;
      #1; chk("t6_b1", 32'(req_ready), 32'h2); tick(); rand_ops(1);
      #1; chk("t6_b2", 32'(req_ready), 32'h2); tick(); rand_ops(1);
      req_valid = 4'b0001;
      #1; chk("t6_gap1", 32'(req_ready), 32'h0); tick();
      #1; chk("t6_gap2", 32'(req_ready), 32'h0); tick();
      req_valid = 4'b0011;
      #1; chk("t6_b3", 32'(req_ready), 32'h2); tick(); rand_ops(1);
      req_lock = 4'b0000;
      #1; chk("t6_b4", 32'(req_ready), 32'h2); tick();
      req_valid = 4'b0001;
      #1; chk("t6_req0", 32'(req_ready), 32'h1); tick();
      drain();
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
